// File: rtl/param_updown_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Holds direction/mode encodings and the phase-width helper.
package param_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Width of a phase counter that counts 0..p-1; never zero.
    function automatic int unsigned phase_width(input int unsigned p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/counter_tick_gen.sv
// Prescaler: asserts tick one cycle in every PRESCALE cycles.
// Ports: clk, reset (sync active-low), tick (1 on the last phase).
module counter_tick_gen
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned PW = phase_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // With PRESCALE==1 LAST is 0, phase never leaves 0 and tick is constant 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
        end else if (phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign tick = (phase == LAST);

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with prescaler, load, wrap/saturate mode.
// Ports: clk, reset, en, up, load, load_val, clr_sticky -> count, overflow, underflow, tc, ovf_sticky.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             tc,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);
    localparam logic SAT = (SATURATE == MODE_SAT);

    logic             tick;
    logic             step;
    logic             at_max;
    logic             at_min;
    logic             hit_max;
    logic             hit_min;
    logic [WIDTH-1:0] load_clamped;

    counter_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign at_max  = (count == LIMIT);
    assign at_min  = (count == '0);
    // A load consumes any coincident tick.
    assign step    = en & tick & ~load;
    assign hit_max = step & (up == DIR_UP) & at_max;
    assign hit_min = step & (up == DIR_DOWN) & at_min;

    assign load_clamped = (load_val > LIMIT) ? LIMIT : load_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            overflow  <= hit_max;
            underflow <= hit_min;
            // A new event beats a coincident clear.
            if (hit_max | hit_min) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
            if (load) begin
                count <= load_clamped;
            end else if (step) begin
                if (up == DIR_UP) begin
                    if (!at_max) begin
                        count <= count + 1'b1;
                    end else if (!SAT) begin
                        count <= '0;
                    end
                end else begin
                    if (!at_min) begin
                        count <= count - 1'b1;
                    end else if (!SAT) begin
                        count <= LIMIT;
                    end
                end
            end
        end
    end

    assign tc = en & ((up == DIR_UP) ? at_max : at_min);

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised self-checking bench for param_updown_counter.
// Four configurations share stimulus; a behavioural model is compared every cycle.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic       clr;
    logic [3:0] lv;

    logic [3:0] cnt [4];
    logic       ovf [4];
    logic       unf [4];
    logic       tcv [4];
    logic       st  [4];

    always #5 clk = ~clk;

    param_updown_counter u_d0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv), .clr_sticky(clr), .count(cnt[0]),
        .overflow(ovf[0]), .underflow(unf[0]), .tc(tcv[0]),
        .ovf_sticky(st[0])
    );

    param_updown_counter #(.SATURATE(1)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv), .clr_sticky(clr), .count(cnt[1]),
        .overflow(ovf[1]), .underflow(unf[1]), .tc(tcv[1]),
        .ovf_sticky(st[1])
    );

    param_updown_counter #(.MAX_VAL(9), .PRESCALE(4)) u_d2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv), .clr_sticky(clr), .count(cnt[2]),
        .overflow(ovf[2]), .underflow(unf[2]), .tc(tcv[2]),
        .ovf_sticky(st[2])
    );

    param_updown_counter #(.MAX_VAL(5), .PRESCALE(3), .SATURATE(1)) u_d3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv), .clr_sticky(clr), .count(cnt[3]),
        .overflow(ovf[3]), .underflow(unf[3]), .tc(tcv[3]),
        .ovf_sticky(st[3])
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit done   = 1'b0;

    int P_MAX [4] = '{15, 15, 9, 5};
    int P_PRE [4] = '{1, 1, 4, 3};
    bit P_SAT [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    int m_cnt [4];
    bit m_ovf [4];
    bit m_unf [4];
    bit m_st  [4];
    int m_cyc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: cycles since reset release; a tick lands on every multiple of PRESCALE.
    always @(posedge clk) begin : model
        bit t;
        int lval;
        if (!reset) begin
            m_cyc = 0;
            for (int k = 0; k < 4; k++) begin
                m_cnt[k] = 0;
                m_ovf[k] = 0;
                m_unf[k] = 0;
                m_st[k]  = 0;
            end
        end else begin
            m_cyc++;
            for (int k = 0; k < 4; k++) begin
                t = (m_cyc % P_PRE[k]) == 0;
                m_ovf[k] = 0;
                m_unf[k] = 0;
                if (load) begin
                    lval = int'(lv);
                    m_cnt[k] = (lval > P_MAX[k]) ? P_MAX[k] : lval;
                end else if (en && t) begin
                    if (up) begin
                        if (m_cnt[k] == P_MAX[k]) begin
                            m_ovf[k] = 1;
                            if (!P_SAT[k]) m_cnt[k] = 0;
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end else begin
                        if (m_cnt[k] == 0) begin
                            m_unf[k] = 1;
                            if (!P_SAT[k]) m_cnt[k] = P_MAX[k];
                        end else begin
                            m_cnt[k] = m_cnt[k] - 1;
                        end
                    end
                end
                if (m_ovf[k] || m_unf[k]) m_st[k] = 1;
                else if (clr) m_st[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("count%0d", k), 32'(cnt[k]), m_cnt[k]);
                chk($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
                chk($sformatf("underflow%0d", k), 32'(unf[k]), 32'(m_unf[k]));
                chk($sformatf("sticky%0d", k), 32'(st[k]), 32'(m_st[k]));
                chk($sformatf("tc%0d", k), 32'(tcv[k]),
                    32'(en && (up ? (m_cnt[k] == P_MAX[k]) : (m_cnt[k] == 0))));
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bias;
        reset = 1'b0; en = 1'b0; up = 1'b1;
        load = 1'b0; clr = 1'b0; lv = 4'd0;
        edge1();
        edge1();
        chk("rst_count", 32'(cnt[0]), 0);
        chk("rst_sticky", 32'(st[0]), 0);
        reset = 1'b1; en = 1'b1; up = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            edge1();
            if (i == 15) begin
                chk("t1_c15", 32'(cnt[0]), 15);
                chk("t1_ovf15", 32'(ovf[0]), 0);
            end
            if (i == 16) begin
                chk("t1_wrap", 32'(cnt[0]), 0);
                chk("t1_ovf", 32'(ovf[0]), 1);
                chk("t1_st", 32'(st[0]), 1);
                chk("t3_sat_c", 32'(cnt[1]), 15);
                chk("t3_sat_ovf", 32'(ovf[1]), 1);
                chk("t4_pre4", 32'(cnt[2]), 4);
                chk("pre3_c", 32'(cnt[3]), 5);
                chk("pre3_ovf", 32'(ovf[3]), 0);
            end
        end

        up = 1'b0;
        edge1();
        chk("t2_down", 32'(cnt[0]), 15);
        chk("t2_unf", 32'(unf[0]), 1);

        en = 1'b0; clr = 1'b1;
        edge1();
        chk("t2_clr", 32'(st[0]), 0);
        chk("t2_unf_gone", 32'(unf[0]), 0);
        clr = 1'b0;

        load = 1'b1; lv = 4'd3; en = 1'b1; up = 1'b1;
        edge1();
        chk("t5_load", 32'(cnt[0]), 3);
        chk("t5_no_ovf", 32'(ovf[0]), 0);

        lv = 4'd15; en = 1'b0;
        edge1();
        load = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b1;
        edge1();
        chk("t5_ovf", 32'(ovf[0]), 1);
        chk("t5_set_wins", 32'(st[0]), 1);
        clr = 1'b0;

        load = 1'b1; lv = 4'd12;
        edge1();
        chk("t4_clamp", 32'(cnt[2]), 9);
        chk("load12", 32'(cnt[0]), 12);
        load = 1'b0;

        reset = 1'b0;
        edge1();
        chk("t6_cnt", 32'(cnt[0]), 0);
        chk("t6_st", 32'(st[0]), 0);
        chk("t6_cnt2", 32'(cnt[2]), 0);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            edge1();
            if (i == 3) chk("t6_pre_wait", 32'(cnt[2]), 0);
            if (i == 4) begin
                chk("t6_pre_step", 32'(cnt[2]), 1);
                chk("t6_d0", 32'(cnt[0]), 4);
            end
        end

        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) bias = int'($urandom_range(10, 90));
            edge1();
            reset = $urandom_range(0, 99) >= 2;
            en    = $urandom_range(0, 3) != 0;
            up    = int'($urandom_range(0, 99)) < bias;
            load  = $urandom_range(0, 15) == 0;
            lv    = 4'($urandom);
            clr   = $urandom_range(0, 9) == 0;
        end

        edge1();
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
